// File: rtl/brcomp_iter.sv
// Iterative RV32I branch comparator: walks the operands one CHUNK per cycle,
// MSB chunk first, and stops at the first chunk that differs.
module brcomp_iter #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic            eq_o,
  output logic            lt_o,
  output logic            taken_o,
  output logic            illegal_o
);

  localparam int N    = XLEN / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT            state, stateNext;
  logic [XLEN-1:0]  rs1Q, rs2Q;
  logic [2:0]       funct3Q;
  logic [IDXW-1:0]  idx;
  logic             eqQ, ltQ;

  logic [CHUNK-1:0] rs1Chunks [N];
  logic [CHUNK-1:0] rs2Chunks [N];
  logic [CHUNK-1:0] chunk1, chunk2;
  logic             chunkDiffer, chunkLt, accept;

  assign accept = (state == IDLE) && valid_i;

  // Select the chunk under examination; flipping the sign bit of the top
  // chunk turns a two's-complement order into a plain unsigned order.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rs1Chunks[i] = rs1Q[i*CHUNK +: CHUNK];
      rs2Chunks[i] = rs2Q[i*CHUNK +: CHUNK];
    end
    chunk1 = rs1Chunks[idx];
    chunk2 = rs2Chunks[idx];
    if ((idx == LAST_IDX) && !funct3Q[1]) begin
      chunk1[CHUNK-1] = ~chunk1[CHUNK-1];
      chunk2[CHUNK-1] = ~chunk2[CHUNK-1];
    end
    chunkDiffer = (chunk1 != chunk2);
    chunkLt     = (chunk1 < chunk2);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNext;
  end

  // NOTE: each always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (valid_i) stateNext = BUSY;
      BUSY:    if (chunkDiffer || (idx == '0)) stateNext = DONE;
      DONE:    if (ready_i) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: operand registers are pure datapath and are only read after a load,
  // so they carry no reset; only the index and the latched results do.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rs1Q    <= rs1_i;
      rs2Q    <= rs2_i;
      funct3Q <= funct3_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx <= LAST_IDX;
      eqQ <= 1'b0;
      ltQ <= 1'b0;
    end else if (accept) begin
      idx <= LAST_IDX;
    end else if (state == BUSY) begin
      if (chunkDiffer) begin
        eqQ <= 1'b0;
        ltQ <= chunkLt;
      end else if (idx == '0) begin
        eqQ <= 1'b1;
        ltQ <= 1'b0;
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end

  // Results are only exposed in DONE and forced low otherwise.
  always_comb begin
    ready_o   = (state == IDLE);
    valid_o   = 1'b0;
    eq_o      = 1'b0;
    lt_o      = 1'b0;
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    if (state == DONE) begin
      valid_o   = 1'b1;
      eq_o      = eqQ;
      lt_o      = ltQ;
      illegal_o = (funct3Q[2:1] == 2'b01);
      case (funct3Q)
        3'b000:         taken_o = eqQ;
        3'b001:         taken_o = ~eqQ;
        3'b100, 3'b110: taken_o = ltQ;
        3'b101, 3'b111: taken_o = ~ltQ;
        default:        taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_brcomp_iter.sv
// Self-checking bench for brcomp_iter: transaction-level model compared every
// cycle, plus directed vectors with hand-computed latency and results.
module tb_brcomp_iter;

  localparam int XLEN  = 32;
  localparam int CHUNK = 8;
  localparam int N     = XLEN / CHUNK;

  logic            clk_i = 1'b0;
  logic            rst_i, valid_i, ready_i;
  logic [XLEN-1:0] rs1_i, rs2_i;
  logic [2:0]      funct3_i;
  logic            ready_o, valid_o, eq_o, lt_o, taken_o, illegal_o;

  brcomp_iter #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i), .valid_o(valid_o),
    .ready_i(ready_i), .eq_o(eq_o), .lt_o(lt_o), .taken_o(taken_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Number of chunks examined: up to and including the most significant differing one.
  function automatic int modelLat(input logic [31:0] a, input logic [31:0] b);
    for (int c = N - 1; c >= 0; c--)
      if ((((a ^ b) >> (c * CHUNK)) & 32'hFF) != 0) return N - c;
    return N;
  endfunction

  function automatic logic modelLt(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    return f3[1] ? (a < b) : ($signed(a) < $signed(b));
  endfunction

  function automatic logic modelTaken(input logic eq, input logic lt, input logic [2:0] f3);
    case (f3)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default:        return 1'b0;
    endcase
  endfunction

  // Transaction model: 0 idle, 1 computing (counting down latency), 2 result held.
  int   mPhase = 0;
  int   mCount = 0;
  logic mEq = 1'b0, mLt = 1'b0, mTaken = 1'b0, mIll = 1'b0;

  always @(posedge clk_i) begin
    if (rst_i) mPhase = 0;
    else begin
      case (mPhase)
        0: if (valid_i) begin
          mCount = modelLat(rs1_i, rs2_i);
          mEq    = (rs1_i == rs2_i);
          mLt    = modelLt(rs1_i, rs2_i, funct3_i);
          mIll   = (funct3_i == 3'b010) || (funct3_i == 3'b011);
          mTaken = mIll ? 1'b0 : modelTaken(mEq, mLt, funct3_i);
          mPhase = 1;
        end
        1: begin
          mCount--;
          if (mCount == 0) mPhase = 2;
        end
        default: if (ready_i) mPhase = 0;
      endcase
    end
  end

  always @(negedge clk_i) begin
    if (checkEn) begin
      check("cyc ready_o",   32'(ready_o),   32'(mPhase == 0));
      check("cyc valid_o",   32'(valid_o),   32'(mPhase == 2));
      check("cyc eq_o",      32'(eq_o),      32'((mPhase == 2) && mEq));
      check("cyc lt_o",      32'(lt_o),      32'((mPhase == 2) && mLt));
      check("cyc taken_o",   32'(taken_o),   32'((mPhase == 2) && mTaken));
      check("cyc illegal_o", 32'(illegal_o), 32'((mPhase == 2) && mIll));
    end
  end

  task automatic runTxn(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input int expLat, input logic expEq,
                        input logic expLt, input logic expTaken, input logic expIll,
                        input int hold);
    int lat;
    @(negedge clk_i);
    rs1_i = a; rs2_i = b; funct3_i = f3; valid_i = 1'b1; ready_i = 1'b0;
    check({tag, " ready before accept"}, 32'(ready_o), 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    // Junk on the inputs while busy must be ignored.
    rs1_i = ~a; rs2_i = b ^ 32'h5A5A5A5A; funct3_i = ~f3; valid_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_i);
      lat++;
      @(negedge clk_i);
    end while (valid_o !== 1'b1 && lat < 20);
    check({tag, " latency"}, 32'(lat), 32'(expLat));
    check({tag, " eq_o"}, 32'(eq_o), 32'(expEq));
    check({tag, " lt_o"}, 32'(lt_o), 32'(expLt));
    check({tag, " taken_o"}, 32'(taken_o), 32'(expTaken));
    check({tag, " illegal_o"}, 32'(illegal_o), 32'(expIll));
    check({tag, " ready_o in done"}, 32'(ready_o), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      check({tag, " hold valid_o"}, 32'(valid_o), 32'd1);
      check({tag, " hold ready_o"}, 32'(ready_o), 32'd0);
      check({tag, " hold eq_o"}, 32'(eq_o), 32'(expEq));
      check({tag, " hold lt_o"}, 32'(lt_o), 32'(expLt));
      check({tag, " hold taken_o"}, 32'(taken_o), 32'(expTaken));
    end
    ready_i = 1'b1; valid_i = 1'b0;
    @(negedge clk_i);
    ready_i = 1'b0;
    check({tag, " valid_o after release"}, 32'(valid_o), 32'd0);
    check({tag, " ready_o after release"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    rs1_i = '0; rs2_i = '0; funct3_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    checkEn = 1'b1;
    check("reset ready_o", 32'(ready_o), 32'd1);
    check("reset valid_o", 32'(valid_o), 32'd0);
    check("reset eq_o", 32'(eq_o), 32'd0);

    //     tag           rs1           rs2           f3      lat eq lt tk il hold
    runTxn("beq equal",  32'h12345678, 32'h12345678, 3'b000, 4, 1, 0, 1, 0, 0);
    runTxn("blt -1<1",   32'hFFFFFFFF, 32'h00000001, 3'b100, 1, 0, 1, 1, 0, 0);
    runTxn("bgeu",       32'hFFFFFFFF, 32'h00000001, 3'b111, 1, 0, 0, 1, 0, 0);
    runTxn("bne bp",     32'h00000100, 32'h00000200, 3'b001, 3, 0, 1, 1, 0, 3);
    runTxn("illegal 010",32'h00000000, 32'h00000000, 3'b010, 4, 1, 0, 0, 1, 0);
    runTxn("bge minint", 32'h80000000, 32'h7FFFFFFF, 3'b101, 1, 0, 1, 0, 0, 0);
    runTxn("bltu minint",32'h80000000, 32'h7FFFFFFF, 3'b110, 1, 0, 0, 0, 0, 1);
    runTxn("blt lsb",    32'h11223344, 32'h11223345, 3'b100, 4, 0, 1, 1, 0, 0);
    runTxn("beq differ", 32'h00000001, 32'h00000002, 3'b000, 4, 0, 1, 0, 0, 0);
    runTxn("illegal 011",32'h00000005, 32'h00000003, 3'b011, 4, 0, 0, 0, 1, 2);
    runTxn("bge neg",    32'hFFFFFF00, 32'hFFFFFFFF, 3'b101, 4, 0, 1, 0, 0, 0);
    runTxn("blt pos/neg",32'h7F000000, 32'h80000000, 3'b100, 1, 0, 0, 0, 0, 0);

    // Reset while comparing the second chunk of an equal pair.
    @(negedge clk_i);
    rs1_i = 32'hCAFEF00D; rs2_i = 32'hCAFEF00D; funct3_i = 3'b000; valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0;
    check("busy reset valid_o", 32'(valid_o), 32'd0);
    check("busy reset ready_o", 32'(ready_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    check("busy reset no pulse", 32'(seen), 32'd0);

    // Reset must win over a simultaneous request in IDLE.
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b1; rs1_i = 32'h1; rs2_i = 32'h2;
    @(negedge clk_i);
    rst_i = 1'b0; valid_i = 1'b0;
    check("reset over valid ready_o", 32'(ready_o), 32'd1);
    check("reset over valid valid_o", 32'(valid_o), 32'd0);

    runTxn("after reset",32'hA5A5A5A5, 32'hA5A5A5A4, 3'b111, 4, 0, 0, 1, 0, 0);

    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
